axi_lat_meter: RTL and testbench
================================

AXI_LAT_METER -- requirements
Module: axi_lat_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of every latency and count output, legal range 8..32.
REQ-002 SHALL have port ACLK, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port ARESET, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports mon_awvalid, mon_awready, mon_bvalid, mon_bready, input, 1 each: passive tap of the monitored AXI4-Lite write address and response channels.
REQ-005 SHALL have ports mon_arvalid, mon_arready, mon_rvalid, mon_rready, input, 1 each: passive tap of the monitored read address and read data channels.
REQ-006 SHALL have port en, input, 1: when 0, no new measurement starts.
REQ-007 SHALL have port clr, input, 1: single-cycle pulse that clears all statistics.
REQ-008 SHALL have ports wr_last_lat, wr_max_lat, wr_min_lat, wr_count, output, CNT_W each: write-channel statistics.
REQ-009 SHALL have ports rd_last_lat, rd_max_lat, rd_min_lat, rd_count, output, CNT_W each: read-channel statistics.
REQ-010 SHALL have ports wr_done and rd_done, output, 1 each: one-cycle pulse when the matching statistics update.
REQ-011 SHALL have ports wr_ovf, rd_ovf, wr_ovl, rd_ovl, output, 1 each: sticky saturation flags (ovf) and overlap flags (ovl).

Function
REQ-012 SHALL contain two identical, independent per-direction FSMs (write: AW->B; read: AR->R), each with states IDLE and BUSY.
REQ-013 SHALL move IDLE->BUSY on an address handshake (valid&ready) in a cycle where en=1, and clear the latency counter to 0.
REQ-014 SHALL increment the counter by 1 every cycle in BUSY, saturating at 2^CNT_W-1; reaching saturation SHALL set the ovf flag.
REQ-015 SHALL define latency as the number of cycles from the address-handshake cycle to the response handshake cycle (B or R valid&ready); a response one cycle after the address handshake gives latency 1.
REQ-016 SHALL, on a response handshake in BUSY, in the next cycle: load last_lat with the latency, update max_lat and min_lat, increment count (saturating), and pulse done for exactly one cycle.
REQ-017 SHALL, on a response handshake in BUSY in the same cycle as a new address handshake, complete the old measurement and start the new one (counter restarts at 0).
REQ-018 SHALL ignore a response handshake in IDLE (stray response); no statistics change.
REQ-019 SHALL ignore an address handshake in BUSY with no same-cycle response, and set the ovl flag.
REQ-020 SHALL, when en falls during BUSY, still complete the in-flight measurement.
REQ-021 SHALL, on clr=1: return both FSMs to IDLE; zero last_lat, max_lat and count; set min_lat to all-ones; clear ovf and ovl; suppress done.
REQ-022 SHALL give clr priority over a same-cycle completion or start; the address handshake in the clr cycle is not measured.
REQ-023 SHALL never drive any mon_* signal; the block is purely observational.

Reset
REQ-024 SHALL, on ARESET=1 at a clock edge, apply the same state as clr: FSMs in IDLE; last/max/count=0; min=all-ones; done=0; ovf=0; ovl=0.
REQ-025 SHALL abandon any in-flight measurement when reset is asserted mid-operation, with no done pulse.

Configuration
REQ-026 SHALL, when macro AXI_LAT_METER_MIN_TRACK_EN is defined, track min_lat as the smallest completed latency per direction.
REQ-027 SHALL, when AXI_LAT_METER_MIN_TRACK_EN is undefined, keep the min_lat ports present, hold them constant at all-ones, and synthesise no min comparator.

Verification
REQ-028 SHALL verify: AW handshake at cycle 10, B handshake at cycle 13 -> wr_last_lat=3, wr_max=3, wr_min=3, wr_count=1, wr_done high at cycle 14 only.
REQ-029 SHALL verify: reads with latencies 5, 2, 9 -> rd_last=9, rd_max=9, rd_min=2 (only with AXI_LAT_METER_MIN_TRACK_EN; otherwise rd_min=0xFFFFFFFF), rd_count=3.
REQ-030 SHALL verify: with CNT_W=8, a response withheld for 300 cycles -> latency reported 255 and wr_ovf=1 until clr.
REQ-031 SHALL verify: a second AW while BUSY -> wr_ovl=1 and the first latency unaffected; a B and a new AW in the same cycle -> completion, then the next latency measured from that cycle.
REQ-032 SHALL verify: clr in the same cycle as a B handshake -> no wr_done, wr_count=0; a stray B in IDLE -> no change.
REQ-033 SHALL verify: ARESET asserted while BUSY -> all outputs at reset values and no done pulse.

Source files
------------

// File: rtl/axi_lat_meter.sv
// axi_lat_meter: passive AXI4-Lite latency meter.
// Measures address-handshake to response-handshake latency independently for
// the write (AW->B) and read (AR->R) directions and keeps last/max/min/count
// statistics with sticky saturation (ovf) and overlap (ovl) flags.
// Optional feature macro: AXI_LAT_METER_MIN_TRACK_EN enables minimum-latency
// tracking; without it the min_lat outputs are held at all-ones.
module axi_lat_meter #(
    parameter int CNT_W = 32
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             mon_awvalid,
    input  logic             mon_awready,
    input  logic             mon_bvalid,
    input  logic             mon_bready,
    input  logic             mon_arvalid,
    input  logic             mon_arready,
    input  logic             mon_rvalid,
    input  logic             mon_rready,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] wr_last_lat,
    output logic [CNT_W-1:0] wr_max_lat,
    output logic [CNT_W-1:0] wr_min_lat,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_last_lat,
    output logic [CNT_W-1:0] rd_max_lat,
    output logic [CNT_W-1:0] rd_min_lat,
    output logic [CNT_W-1:0] rd_count,
    output logic             wr_done,
    output logic             rd_done,
    output logic             wr_ovf,
    output logic             rd_ovf,
    output logic             wr_ovl,
    output logic             rd_ovl
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Index 0 is the write direction, index 1 the read direction.
    logic [1:0]            addr_hs;
    logic [1:0]            resp_hs;
    logic [1:0][CNT_W-1:0] last_all;
    logic [1:0][CNT_W-1:0] max_all;
    logic [1:0][CNT_W-1:0] min_all;
    logic [1:0][CNT_W-1:0] count_all;
    logic [1:0]            done_all;
    logic [1:0]            ovf_all;
    logic [1:0]            ovl_all;
    logic                  clear;

    // Reset and clr put the meter into the identical cleared state.
    assign clear   = ARESET | clr;
    assign addr_hs = {mon_arvalid & mon_arready, mon_awvalid & mon_awready};
    assign resp_hs = {mon_rvalid & mon_rready, mon_bvalid & mon_bready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dir
            state_t           state_reg;
            state_t           state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] lat_now;
            logic [CNT_W-1:0] last_reg;
            logic [CNT_W-1:0] max_reg;
            logic [CNT_W-1:0] count_reg;
            logic             done_reg;
            logic             ovf_reg;
            logic             ovl_reg;
            logic             finish;
            logic             start;

            // Next state: a response in BUSY completes; an enabled address
            // handshake starts, even in the same cycle as a completion.
            always_comb begin
                state_next = state_reg;
                lat_now    = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
                finish     = (state_reg == BUSY) && resp_hs[gi];
                start      = en && addr_hs[gi] && ((state_reg == IDLE) || finish);
                if (start) begin
                    state_next = BUSY;
                end else if (finish) begin
                    state_next = IDLE;
                end
            end

            // FSM state register
            always_ff @(posedge ACLK) begin
                if (clear) begin
                    state_reg <= IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Latency counter (saturating) and sticky overflow flag
            always_ff @(posedge ACLK) begin
                if (clear) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else begin
                    if (start) begin
                        cnt_reg <= '0;
                    end else if (state_reg == BUSY) begin
                        cnt_reg <= lat_now;
                    end
                    if ((state_reg == BUSY) && (lat_now == CNT_MAX)) begin
                        ovf_reg <= 1'b1;
                    end
                end
            end

            // Sticky overlap flag: a new address while a measurement is open
            always_ff @(posedge ACLK) begin
                if (clear) begin
                    ovl_reg <= 1'b0;
                end else if ((state_reg == BUSY) && addr_hs[gi] && !resp_hs[gi]) begin
                    ovl_reg <= 1'b1;
                end
            end

            // Statistics update and done pulse, one cycle after completion
            always_ff @(posedge ACLK) begin
                if (clear) begin
                    last_reg  <= '0;
                    max_reg   <= '0;
                    count_reg <= '0;
                    done_reg  <= 1'b0;
                end else begin
                    done_reg <= finish;
                    if (finish) begin
                        last_reg  <= lat_now;
                        if (lat_now > max_reg) begin
                            max_reg <= lat_now;
                        end
                        count_reg <= (count_reg == CNT_MAX) ? CNT_MAX : count_reg + 1'b1;
                    end
                end
            end

`ifdef AXI_LAT_METER_MIN_TRACK_EN
            logic [CNT_W-1:0] min_reg;

            // Smallest completed latency
            always_ff @(posedge ACLK) begin
                if (clear) begin
                    min_reg <= CNT_MAX;
                end else if (finish && (lat_now < min_reg)) begin
                    min_reg <= lat_now;
                end
            end

            assign min_all[gi] = min_reg;
`else
            assign min_all[gi] = CNT_MAX;
`endif

            assign last_all[gi]  = last_reg;
            assign max_all[gi]   = max_reg;
            assign count_all[gi] = count_reg;
            assign done_all[gi]  = done_reg;
            assign ovf_all[gi]   = ovf_reg;
            assign ovl_all[gi]   = ovl_reg;
        end
    endgenerate

    assign wr_last_lat = last_all[0];
    assign wr_max_lat  = max_all[0];
    assign wr_min_lat  = min_all[0];
    assign wr_count    = count_all[0];
    assign wr_done     = done_all[0];
    assign wr_ovf      = ovf_all[0];
    assign wr_ovl      = ovl_all[0];
    assign rd_last_lat = last_all[1];
    assign rd_max_lat  = max_all[1];
    assign rd_min_lat  = min_all[1];
    assign rd_count    = count_all[1];
    assign rd_done     = done_all[1];
    assign rd_ovf      = ovf_all[1];
    assign rd_ovl      = ovl_all[1];

endmodule

// File: tb/tb_axi_lat_meter.sv
// Self-checking bench for axi_lat_meter: table-driven transactions plus
// hand-written corner sequences; a scoreboard queue per direction holds the
// expected latency of every completion and is checked on each done pulse.
module tb_axi_lat_meter;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic ARESET, en, clr;
    logic awv, awr, bv, br, arv, arr, rv, rr;
    logic [31:0] wr_last_lat, wr_max_lat, wr_min_lat, wr_count;
    logic [31:0] rd_last_lat, rd_max_lat, rd_min_lat, rd_count;
    logic wr_done, rd_done, wr_ovf, rd_ovf, wr_ovl, rd_ovl;

    // Narrow instance used for the saturation test
    logic aw8, b8, clr8;
    logic [7:0] wr_last8, wr_max8, wr_min8, wr_count8;
    logic [7:0] rd_last8, rd_max8, rd_min8, rd_count8;
    logic wr_done8, rd_done8, wr_ovf8, rd_ovf8, wr_ovl8, rd_ovl8;

    int tests = 0;
    int fails = 0;
    int wq[$];
    int rq[$];

    axi_lat_meter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .mon_awvalid(awv), .mon_awready(awr), .mon_bvalid(bv), .mon_bready(br),
        .mon_arvalid(arv), .mon_arready(arr), .mon_rvalid(rv), .mon_rready(rr),
        .en(en), .clr(clr),
        .wr_last_lat(wr_last_lat), .wr_max_lat(wr_max_lat), .wr_min_lat(wr_min_lat), .wr_count(wr_count),
        .rd_last_lat(rd_last_lat), .rd_max_lat(rd_max_lat), .rd_min_lat(rd_min_lat), .rd_count(rd_count),
        .wr_done(wr_done), .rd_done(rd_done),
        .wr_ovf(wr_ovf), .rd_ovf(rd_ovf), .wr_ovl(wr_ovl), .rd_ovl(rd_ovl)
    );

    axi_lat_meter #(.CNT_W(8)) dut8 (
        .ACLK(ACLK), .ARESET(ARESET),
        .mon_awvalid(aw8), .mon_awready(aw8), .mon_bvalid(b8), .mon_bready(b8),
        .mon_arvalid(1'b0), .mon_arready(1'b0), .mon_rvalid(1'b0), .mon_rready(1'b0),
        .en(1'b1), .clr(clr8),
        .wr_last_lat(wr_last8), .wr_max_lat(wr_max8), .wr_min_lat(wr_min8), .wr_count(wr_count8),
        .rd_last_lat(rd_last8), .rd_max_lat(rd_max8), .rd_min_lat(rd_min8), .rd_count(rd_count8),
        .wr_done(wr_done8), .rd_done(rd_done8),
        .wr_ovf(wr_ovf8), .rd_ovf(rd_ovf8), .wr_ovl(wr_ovl8), .rd_ovl(rd_ovl8)
    );

    typedef struct {
        bit rd;
        int lat;
        int e_last;
        int e_max;
        int e_min;
        int e_count;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Expected min_lat given the tracked minimum
    function automatic logic [63:0] emin(input int v);
`ifdef AXI_LAT_METER_MIN_TRACK_EN
        return 64'(v);
`else
        return 64'hFFFF_FFFF;
`endif
    endfunction

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic addr(input bit rd, input bit v);
        if (rd) begin arv = v; arr = v; end
        else begin awv = v; awr = v; end
    endtask

    task automatic resp(input bit rd, input bit v);
        if (rd) begin rv = v; rr = v; end
        else begin bv = v; br = v; end
    endtask

    task automatic push(input bit rd, input int lat);
        if (rd) rq.push_back(lat);
        else wq.push_back(lat);
    endtask

    // Address handshake, then the response exactly lat cycles later.
    // Returns in the cycle where done is expected high.
    task automatic do_txn(input bit rd, input int lat);
        addr(rd, 1'b1);
        cyc();
        addr(rd, 1'b0);
        repeat (lat - 1) cyc();
        resp(rd, 1'b1);
        push(rd, lat);
        cyc();
        resp(rd, 1'b0);
    endtask

    // Scoreboard: each done pulse pops one expected latency
    always @(negedge ACLK) begin
        int e;
        if (wr_done === 1'b1) begin
            if (wq.size() == 0) begin
                tests++; fails++;
                $display("FAIL wr_done_unexpected: got done=1 required no completion");
            end else begin
                e = wq.pop_front();
                $display("[TB] wr txn lat=%0d count=%0d", wr_last_lat, wr_count);
                chk("wr_last_lat_sb", 64'(wr_last_lat), 64'(e));
            end
        end
        if (rd_done === 1'b1) begin
            if (rq.size() == 0) begin
                tests++; fails++;
                $display("FAIL rd_done_unexpected: got done=1 required no completion");
            end else begin
                e = rq.pop_front();
                $display("[TB] rd txn lat=%0d count=%0d", rd_last_lat, rd_count);
                chk("rd_last_lat_sb", 64'(rd_last_lat), 64'(e));
            end
        end
    end

    task automatic chk_cleared(input string tag);
        chk({tag, "_wr_last"},  64'(wr_last_lat), 64'h0);
        chk({tag, "_wr_max"},   64'(wr_max_lat),  64'h0);
        chk({tag, "_wr_min"},   64'(wr_min_lat),  64'hFFFF_FFFF);
        chk({tag, "_wr_count"}, 64'(wr_count),    64'h0);
        chk({tag, "_wr_done"},  64'(wr_done),     64'h0);
        chk({tag, "_wr_ovf"},   64'(wr_ovf),      64'h0);
        chk({tag, "_wr_ovl"},   64'(wr_ovl),      64'h0);
        chk({tag, "_rd_last"},  64'(rd_last_lat), 64'h0);
        chk({tag, "_rd_max"},   64'(rd_max_lat),  64'h0);
        chk({tag, "_rd_min"},   64'(rd_min_lat),  64'hFFFF_FFFF);
        chk({tag, "_rd_count"}, 64'(rd_count),    64'h0);
        chk({tag, "_rd_done"},  64'(rd_done),     64'h0);
        chk({tag, "_rd_ovf"},   64'(rd_ovf),      64'h0);
        chk({tag, "_rd_ovl"},   64'(rd_ovl),      64'h0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 3, 3, 3, 3, 1};
        vecs[1] = '{1'b1, 5, 5, 5, 5, 1};
        vecs[2] = '{1'b0, 1, 1, 3, 1, 2};
        vecs[3] = '{1'b1, 2, 2, 5, 2, 2};
        vecs[4] = '{1'b0, 7, 7, 7, 1, 3};
        vecs[5] = '{1'b1, 9, 9, 9, 2, 3};

        ARESET = 1'b1; en = 1'b0; clr = 1'b0;
        awv = 0; awr = 0; bv = 0; br = 0; arv = 0; arr = 0; rv = 0; rr = 0;
        aw8 = 0; b8 = 0; clr8 = 0;
        repeat (3) cyc();
        chk_cleared("reset");
        ARESET = 1'b0;
        en = 1'b1;
        cyc();

        // Table-driven transactions
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].rd, vecs[i].lat);
            chk($sformatf("v%0d_done_high", i), 64'(vecs[i].rd ? rd_done : wr_done), 64'h1);
            cyc();
            chk($sformatf("v%0d_done_low", i), 64'(vecs[i].rd ? rd_done : wr_done), 64'h0);
            chk($sformatf("v%0d_last", i),  64'(vecs[i].rd ? rd_last_lat : wr_last_lat), 64'(vecs[i].e_last));
            chk($sformatf("v%0d_max", i),   64'(vecs[i].rd ? rd_max_lat : wr_max_lat), 64'(vecs[i].e_max));
            chk($sformatf("v%0d_min", i),   64'(vecs[i].rd ? rd_min_lat : wr_min_lat), emin(vecs[i].e_min));
            chk($sformatf("v%0d_count", i), 64'(vecs[i].rd ? rd_count : wr_count), 64'(vecs[i].e_count));
        end
        chk("no_ovl_yet", 64'(wr_ovl), 64'h0);
        chk("no_ovf_32", 64'(wr_ovf), 64'h0);

        // Second AW while BUSY: flagged, first latency unaffected (6)
        addr(0, 1'b1); cyc(); addr(0, 1'b0); cyc();
        addr(0, 1'b1); cyc(); addr(0, 1'b0);
        repeat (3) cyc();
        resp(0, 1'b1); push(0, 6); cyc(); resp(0, 1'b0);
        chk("ovl_set", 64'(wr_ovl), 64'h1);
        chk("ovl_last", 64'(wr_last_lat), 64'd6);

        // B and new AW in the same cycle: complete 4, then measure 3
        addr(0, 1'b1); cyc(); addr(0, 1'b0);
        repeat (3) cyc();
        resp(0, 1'b1); addr(0, 1'b1); push(0, 4); cyc();
        resp(0, 1'b0); addr(0, 1'b0);
        chk("b2b_first", 64'(wr_last_lat), 64'd4);
        repeat (2) cyc();
        resp(0, 1'b1); push(0, 3); cyc(); resp(0, 1'b0);
        chk("b2b_second", 64'(wr_last_lat), 64'd3);
        chk("b2b_count", 64'(wr_count), 64'd6);
        chk("b2b_max", 64'(wr_max_lat), 64'd7);

        // en falls while BUSY: measurement still completes
        addr(0, 1'b1); cyc(); addr(0, 1'b0); en = 1'b0;
        repeat (3) cyc();
        resp(0, 1'b1); push(0, 4); cyc(); resp(0, 1'b0);
        chk("en_fall_last", 64'(wr_last_lat), 64'd4);
        chk("en_fall_count", 64'(wr_count), 64'd7);
        // en=0: no measurement starts, following B is stray
        addr(0, 1'b1); cyc(); addr(0, 1'b0); cyc();
        resp(0, 1'b1); cyc(); resp(0, 1'b0); cyc();
        chk("en_off_count", 64'(wr_count), 64'd7);
        en = 1'b1;
        // AWVALID without AWREADY is not a handshake
        awv = 1'b1; cyc(); awv = 1'b0; cyc();
        resp(0, 1'b1); cyc(); resp(0, 1'b0); cyc();
        chk("no_ready_count", 64'(wr_count), 64'd7);

        // clr in the same cycle as a B handshake
        addr(0, 1'b1); addr(1, 1'b1); cyc(); addr(0, 1'b0); addr(1, 1'b0); cyc();
        resp(0, 1'b1); clr = 1'b1; cyc(); resp(0, 1'b0); clr = 1'b0;
        chk_cleared("clr");
        // Stray responses in IDLE change nothing
        resp(0, 1'b1); resp(1, 1'b1); cyc(); resp(0, 1'b0); resp(1, 1'b0); cyc();
        chk("stray_wr_count", 64'(wr_count), 64'h0);
        chk("stray_rd_count", 64'(rd_count), 64'h0);
        chk("stray_wr_last", 64'(wr_last_lat), 64'h0);
        do_txn(0, 2);
        cyc();
        chk("post_clr_last", 64'(wr_last_lat), 64'd2);
        chk("post_clr_min", 64'(wr_min_lat), emin(2));
        chk("post_clr_count", 64'(wr_count), 64'd1);

        // Saturation on the 8-bit instance: response withheld 300 cycles
        aw8 = 1'b1; cyc(); aw8 = 1'b0;
        repeat (299) cyc();
        b8 = 1'b1; cyc(); b8 = 1'b0;
        chk("sat_done", 64'(wr_done8), 64'h1);
        chk("sat_last", 64'(wr_last8), 64'd255);
        chk("sat_max", 64'(wr_max8), 64'd255);
        chk("sat_min", 64'(wr_min8), 64'd255);
        chk("sat_count", 64'(wr_count8), 64'd1);
        chk("sat_ovf", 64'(wr_ovf8), 64'h1);
        chk("sat_ovl", 64'(wr_ovl8), 64'h0);
        chk("sat_rd_quiet", 64'({rd_last8, rd_max8, rd_count8, rd_done8, rd_ovf8, rd_ovl8}), 64'h0);
        chk("sat_rd_min", 64'(rd_min8), 64'hFF);
        repeat (5) cyc();
        chk("sat_ovf_sticky", 64'(wr_ovf8), 64'h1);
        clr8 = 1'b1; cyc(); clr8 = 1'b0;
        chk("sat_ovf_clr", 64'(wr_ovf8), 64'h0);
        chk("sat_last_clr", 64'(wr_last8), 64'h0);

        // Reset while both directions are BUSY, with responses in that cycle
        addr(0, 1'b1); addr(1, 1'b1); cyc(); addr(0, 1'b0); addr(1, 1'b0); cyc();
        resp(0, 1'b1); resp(1, 1'b1); ARESET = 1'b1; cyc();
        resp(0, 1'b0); resp(1, 1'b0); ARESET = 1'b0;
        chk_cleared("midrst");
        cyc();
        chk("midrst_wr_done", 64'(wr_done), 64'h0);
        chk("midrst_rd_done", 64'(rd_done), 64'h0);
        do_txn(1, 2);
        cyc();
        chk("midrst_rd_last", 64'(rd_last_lat), 64'd2);
        chk("midrst_rd_count", 64'(rd_count), 64'd1);

        repeat (3) cyc();
        chk("wq_drained", 64'(wq.size()), 64'h0);
        chk("rq_drained", 64'(rq.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
